// File: rtl/vga_mem_pkg.sv
// Shared widths, clear length and state/requester types for the VGA frame-memory port-A controller.
package vga_mem_pkg;

    localparam int unsigned ADDR_W      = 16;
    localparam int unsigned DATA_W      = 8;
    localparam int unsigned CLEAR_WORDS = 19200;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    typedef enum logic {
        REQ0 = 1'b0,
        REQ1 = 1'b1
    } req_id_t;

endpackage

// File: rtl/vga_clear_seq.sv
// Frame-clear sequencer: walks addresses 0..CLEAR_WORDS-1 writing one latched colour, then pulses done.
module vga_clear_seq #(
    parameter int unsigned ADDR_W      = vga_mem_pkg::ADDR_W,
    parameter int unsigned DATA_W      = vga_mem_pkg::DATA_W,
    parameter int unsigned CLEAR_WORDS = vga_mem_pkg::CLEAR_WORDS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] color,
    output logic              busy,
    output logic              done,
    output logic              last,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CLEAR_WORDS - 1);

    logic [ADDR_W-1:0] cnt;
    logic [DATA_W-1:0] color_q;

    assign last = busy && (cnt == LAST_ADDR);
    assign addr = cnt;
    assign data = color_q;

    // Counter stops at the final address, so it never wraps even for a full-memory clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            color_q <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start && !busy) begin
                cnt     <= '0;
                color_q <= color;
                busy    <= 1'b1;
            end else if (busy) begin
                if (last) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end else begin
                    cnt <= cnt + ADDR_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/vga_mem_ctrl.sv
// Port-A controller for VGA_Mem: round-robin arbitration of two requesters plus a whole-frame clear.
module vga_mem_ctrl #(
    parameter int unsigned ADDR_W      = vga_mem_pkg::ADDR_W,
    parameter int unsigned DATA_W      = vga_mem_pkg::DATA_W,
    parameter int unsigned CLEAR_WORDS = vga_mem_pkg::CLEAR_WORDS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              r0_valid,
    input  logic              r0_we,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic              r0_ready,
    output logic              r0_rvalid,
    output logic [DATA_W-1:0] r0_rdata,
    input  logic              r1_valid,
    input  logic              r1_we,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r1_ready,
    output logic              r1_rvalid,
    output logic [DATA_W-1:0] r1_rdata,
    input  logic              clr_start,
    input  logic [DATA_W-1:0] clr_color,
    output logic              clr_busy,
    output logic              clr_done,
    output logic [ADDR_W-1:0] mem_addr_a,
    output logic [DATA_W-1:0] mem_data_a,
    output logic              mem_we_a,
    input  logic [DATA_W-1:0] mem_q_a
);

    import vga_mem_pkg::*;

    state_t            state;
    req_id_t           last_grant;
    req_id_t           winner;
    logic              idle;
    logic              grant;
    logic              seq_start;
    logic              seq_last;
    logic [ADDR_W-1:0] seq_addr;
    logic [DATA_W-1:0] seq_data;
    logic              r0_pend;
    logic              r1_pend;

    // Reset forces every combinational output low immediately, not just at the next edge.
    assign idle      = (state == IDLE) && !rst;
    assign seq_start = idle && clr_start;

    always_comb begin
        winner = REQ0;
        if (r0_valid && r1_valid) begin
            winner = (last_grant == REQ1) ? REQ0 : REQ1;
        end else if (r1_valid) begin
            winner = REQ1;
        end
    end

    assign r0_ready = idle && r0_valid && (winner == REQ0);
    assign r1_ready = idle && r1_valid && (winner == REQ1);
    assign grant    = r0_ready || r1_ready;

    always_comb begin
        mem_addr_a = '0;
        mem_data_a = '0;
        mem_we_a   = 1'b0;
        if (state == CLEAR && !rst) begin
            mem_addr_a = seq_addr;
            mem_data_a = seq_data;
            mem_we_a   = 1'b1;
        end else if (grant) begin
            if (winner == REQ1) begin
                mem_addr_a = r1_addr;
                mem_data_a = r1_wdata;
                mem_we_a   = r1_we;
            end else begin
                mem_addr_a = r0_addr;
                mem_data_a = r0_wdata;
                mem_we_a   = r0_we;
            end
        end
    end

    // Port-A FSM, round-robin pointer and one-cycle read-return flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= REQ1;
            r0_pend    <= 1'b0;
            r1_pend    <= 1'b0;
        end else begin
            r0_pend <= r0_ready && !r0_we;
            r1_pend <= r1_ready && !r1_we;
            if (grant) begin
                last_grant <= winner;
            end
            case (state)
                IDLE:    if (clr_start) state <= CLEAR;
                CLEAR:   if (seq_last)  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Synchronous memory presents q_a in the cycle after the read handshake.
    assign r0_rvalid = r0_pend;
    assign r1_rvalid = r1_pend;
    assign r0_rdata  = r0_pend ? mem_q_a : '0;
    assign r1_rdata  = r1_pend ? mem_q_a : '0;

    vga_clear_seq #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .CLEAR_WORDS (CLEAR_WORDS)
    ) u_clear_seq (
        .clk   (clk),
        .rst   (rst),
        .start (seq_start),
        .color (clr_color),
        .busy  (clr_busy),
        .done  (clr_done),
        .last  (seq_last),
        .addr  (seq_addr),
        .data  (seq_data)
    );

endmodule

// File: doc/vga_mem_ctrl.md
# vga_mem_ctrl

Port-A controller for the VGA frame memory (`VGA_Mem`: 8-bit data, 16-bit address, synchronous single-cycle port A). Two requesters share port A through a round-robin arbiter with valid/ready handshakes:
- r0: game-logic cell painter
- r1: line-clear/scroll engine

A built-in clear sequencer fills the whole frame with one colour on command. Port B stays owned by the VGA scan-out and is not touched by this block.

## Interface
Parameters:
- `ADDR_W`, 16, memory address width
- `DATA_W`, 8, memory data width
- `CLEAR_WORDS`, 19200, words written by a clear; 1 ≤ value ≤ 2^ADDR_W

Ports:
- `clk` in 1: single clock
- `rst` in 1: asynchronous, active-high reset
- `r0_valid` in 1: request 0 present
- `r0_we` in 1: 1 = write, 0 = read
- `r0_addr` in ADDR_W: request address
- `r0_wdata` in DATA_W: write data
- `r0_ready` out 1: request 0 accepted this cycle
- `r0_rvalid` out 1: read data valid for request 0
- `r0_rdata` out DATA_W: read data
- `r1_*`: same seven signals for requester 1
- `clr_start` in 1: start a clear (sampled only in IDLE)
- `clr_color` in DATA_W: fill value, captured with `clr_start`
- `clr_busy` out 1: clear in progress
- `clr_done` out 1: one-cycle pulse when a clear completes
- `mem_addr_a` out ADDR_W: to `VGA_Mem.addr_a`
- `mem_data_a` out DATA_W: to `VGA_Mem.data_a`
- `mem_we_a` out 1: to `VGA_Mem.we_a`
- `mem_q_a` in DATA_W: from `VGA_Mem.q_a`

## Operation
- FSM states:
  - IDLE: arbitrate r0/r1.
  - CLEAR: sequencer owns port A. Both `rX_ready` are 0.
- Transitions:
  - IDLE→CLEAR at the edge where `clr_start`=1. `clr_color` is latched and the counter is set to 0.
  - CLEAR→IDLE at the edge that commits the write to address `CLEAR_WORDS-1`.
  - `clr_start` in CLEAR is ignored; no queuing.
- Arbitration in IDLE is round-robin with a `last_grant` bit:
  - Only one valid: that requester wins.
  - Both valid: the requester not in `last_grant` wins. `last_grant` updates on every handshake.
  - `rX_ready` is combinational: valid AND winner AND state==IDLE.
  - Handshake = valid & ready. The requester holds addr/data/we stable until its handshake.
- Memory drive:
  - With a grant, `mem_addr_a`, `mem_data_a` and `mem_we_a` come combinationally from the winner.
  - In CLEAR they are driven as addr=counter, data=latched colour, we=1.
  - Otherwise addr=0, data=0, we=0.
- Read return:
  - A read handshake sets `rX_rvalid`=1 for exactly the next cycle, with `rX_rdata` = `mem_q_a`.
  - Outside that cycle, `rX_rdata` = 0.
  - A write handshake produces no rvalid.
- `clr_start` in the same cycle as requests: that cycle's grant still completes and the clear begins next cycle.
- Clear counter is ADDR_W wide and never wraps. Compare against `CLEAR_WORDS-1`.
- Reset:
  - Asynchronous; legal mid-clear or mid-read, and aborts all activity.
  - After reset: state=IDLE, counter=0, `last_grant`=r1 (so r0 wins the first tie).
  - All outputs are 0, including a pending rvalid, which is dropped.

## Timing
- Throughput is one port-A access per cycle, with zero arbitration bubbles between grants.
- Write commits at the handshake edge.
- Read: handshake at edge N; `rX_rvalid`/`rdata` valid in cycle N+1.
- Clear timing, with `clr_start` seen at edge S:
  - `clr_busy`=1 from cycle S+1 through S+`CLEAR_WORDS`.
  - Writes occur on cycles S+1 … S+`CLEAR_WORDS`.
  - `clr_done`=1 on cycle S+`CLEAR_WORDS`+1 only. `clr_busy` is 0 in that cycle and requests may be granted.
- `clr_busy`, `clr_done`, `rX_rvalid` and `rX_rdata` are registered or derived from registered state.
- `rX_ready` and the `mem_*` outputs are combinational from inputs and state.

## Structure
- Shared package `vga_mem_pkg`:
  - `ADDR_W`, `DATA_W`, `CLEAR_WORDS` defaults
  - state enum {IDLE, CLEAR}
  - requester-id type (0/1)
- Sub-module `vga_clear_seq`:
  - Owns the counter, colour latch and busy/done generation.
  - start/done interface to the top FSM.
- Arbiter and read-return tracking stay in `vga_mem_ctrl`.

## Test plan
- Reset, then r0 writes 200 to addr 0, then r1 reads addr 0:
  - `r0_ready`=1 same cycle.
  - `r1_rvalid`=1 with `r1_rdata`=200 exactly one cycle after the read handshake.
- r0 and r1 both held valid for 6 cycles (writes to addrs 10 and 11):
  - Grants alternate r0, r1, r0, …, starting with r0.
  - `mem_we_a`=1 every cycle.
- `clr_start` with `clr_color`=8'h5A and `CLEAR_WORDS`=16:
  - `clr_busy` is high for 16 cycles.
  - Requests stall (ready=0).
  - `clr_done` pulses on cycle 17.
  - Port-B reads of addrs 0–15 return 8'h5A.
- `clr_start` pulsed again mid-clear: ignored; `clr_done` occurs once at the original time.
- Assert `rst` at clear cycle 5 and during a pending read:
  - All outputs are 0 immediately.
  - No `clr_done` and no rvalid.
  - After release, r0 wins the first tie.
- Sweep r0 write then read for addrs 0–2095 with data = addr[7:0]: every `r0_rdata` equals addr[7:0].
